// File: rtl/pipeline_control_unit.sv
// Control path for a 5-stage RV32I pipeline: D decode, D/E-E/M-M/W control registers, E branch resolve, hazard stall/flush.
// Define LOAD_USE_STALL_EN to compute the load-use stall internally; otherwise StallIn supplies it.
module pipeline_control_unit #(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int IMM_SRC_WIDTH  = 3,
  parameter int ALU_OP_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OP_WIDTH-1:0]       opD,
  input  logic [FUNCT3_WIDTH-1:0]   funct3D,
  input  logic                      funct7_5D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      ZeroE,
  input  logic                      NE,
  input  logic                      CE,
  input  logic                      VE,
  input  logic                      StallIn,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrcD,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic                      ALUSrcE,
  output logic                      PCSrcE,
  output logic                      MemWriteM,
  output logic [1:0]                ResultSrcW,
  output logic                      RegWriteM,
  output logic                      RegWriteW,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic [REG_ADDR_WIDTH-1:0] RdM,
  output logic [REG_ADDR_WIDTH-1:0] RdW,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE
);

  localparam logic [OP_WIDTH-1:0] OPC_LOAD   = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OPC_STORE  = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OPC_R      = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OPC_I      = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OPC_BRANCH = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OPC_JAL    = OP_WIDTH'(7'b1101111);
  localparam logic [OP_WIDTH-1:0] OPC_JALR   = OP_WIDTH'(7'b1100111);
  localparam logic [OP_WIDTH-1:0] OPC_LUI    = OP_WIDTH'(7'b0110111);
  localparam logic [OP_WIDTH-1:0] OPC_AUIPC  = OP_WIDTH'(7'b0010111);

  localparam logic [IMM_SRC_WIDTH-1:0] IMM_I = IMM_SRC_WIDTH'(3'b000);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_S = IMM_SRC_WIDTH'(3'b001);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_B = IMM_SRC_WIDTH'(3'b010);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_J = IMM_SRC_WIDTH'(3'b011);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_U = IMM_SRC_WIDTH'(3'b100);

  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_ADD = ALU_OP_WIDTH'(3'd0);
  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_SUB = ALU_OP_WIDTH'(3'd1);
  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_R   = ALU_OP_WIDTH'(3'd2);
  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_I   = ALU_OP_WIDTH'(3'd3);
  localparam logic [ALU_OP_WIDTH-1:0] ALUOP_LUI = ALU_OP_WIDTH'(3'd4);

  // ALUControl encoding shared with the datapath ALU; add is 0 so a bubble is harmless
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD   = ALU_CTRL_WIDTH'(4'h0);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB   = ALU_CTRL_WIDTH'(4'h1);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND   = ALU_CTRL_WIDTH'(4'h2);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR    = ALU_CTRL_WIDTH'(4'h3);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR   = ALU_CTRL_WIDTH'(4'h4);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT   = ALU_CTRL_WIDTH'(4'h5);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU  = ALU_CTRL_WIDTH'(4'h6);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL   = ALU_CTRL_WIDTH'(4'h7);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL   = ALU_CTRL_WIDTH'(4'h8);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA   = ALU_CTRL_WIDTH'(4'h9);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASSB = ALU_CTRL_WIDTH'(4'hA);

  logic                      valid_d;
  logic                      reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d;
  logic [1:0]                result_src_d;
  logic [IMM_SRC_WIDTH-1:0]  imm_src_d;
  logic [ALU_OP_WIDTH-1:0]   alu_op_d;
  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_d;
  logic [REG_ADDR_WIDTH-1:0] rd_d;

  logic                      reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e;
  logic [1:0]                result_src_e;
  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_e;
  logic [FUNCT3_WIDTH-1:0]   funct3_e;
  logic [REG_ADDR_WIDTH-1:0] rd_e;

  logic                      reg_write_m, mem_write_m;
  logic [1:0]                result_src_m;
  logic [REG_ADDR_WIDTH-1:0] rd_m;

  logic                      reg_write_w;
  logic [1:0]                result_src_w;
  logic [REG_ADDR_WIDTH-1:0] rd_w;

  logic lt, ltu, taken, pc_src, lw_stall;

  always_comb begin
    valid_d      = 1'b1;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    alu_src_d    = 1'b0;
    result_src_d = 2'b00;
    imm_src_d    = IMM_I;
    alu_op_d     = ALUOP_ADD;
    case (opD)
      OPC_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
        alu_src_d    = 1'b1;
      end
      OPC_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = IMM_S;
      end
      OPC_R: begin
        reg_write_d = 1'b1;
        alu_op_d    = ALUOP_R;
      end
      OPC_I: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_op_d    = ALUOP_I;
      end
      OPC_BRANCH: begin
        branch_d  = 1'b1;
        imm_src_d = IMM_B;
        alu_op_d  = ALUOP_SUB;
      end
      OPC_JAL: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
        imm_src_d    = IMM_J;
      end
      OPC_JALR: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
        alu_src_d    = 1'b1;
      end
      OPC_LUI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = IMM_U;
        alu_op_d    = ALUOP_LUI;
      end
      OPC_AUIPC: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = IMM_U;
      end
      default: valid_d = 1'b0;
    endcase
  end

  // funct7_5 selects sub only for register-register ops; for I-type it is immediate bit 10
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    case (alu_op_d)
      ALUOP_SUB: alu_ctrl_d = ALU_SUB;
      ALUOP_LUI: alu_ctrl_d = ALU_PASSB;
      ALUOP_R, ALUOP_I: begin
        case (funct3D)
          3'b000:  alu_ctrl_d = (alu_op_d == ALUOP_R && funct7_5D) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_d = ALU_SLL;
          3'b010:  alu_ctrl_d = ALU_SLT;
          3'b011:  alu_ctrl_d = ALU_SLTU;
          3'b100:  alu_ctrl_d = ALU_XOR;
          3'b101:  alu_ctrl_d = funct7_5D ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_d = ALU_OR;
          3'b111:  alu_ctrl_d = ALU_AND;
          default: alu_ctrl_d = ALU_ADD;
        endcase
      end
      default: alu_ctrl_d = ALU_ADD;
    endcase
  end

  assign rd_d    = valid_d ? RdD : '0;
  assign ImmSrcD = imm_src_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      alu_src_e    <= 1'b0;
      result_src_e <= 2'b00;
      alu_ctrl_e   <= '0;
      funct3_e     <= '0;
      rd_e         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      rd_m         <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= '0;
    end else begin
      if (FlushE) begin
        reg_write_e  <= 1'b0;
        mem_write_e  <= 1'b0;
        branch_e     <= 1'b0;
        jump_e       <= 1'b0;
        alu_src_e    <= 1'b0;
        result_src_e <= 2'b00;
        alu_ctrl_e   <= '0;
        funct3_e     <= '0;
        rd_e         <= '0;
      end else begin
        reg_write_e  <= reg_write_d;
        mem_write_e  <= mem_write_d;
        branch_e     <= branch_d;
        jump_e       <= jump_d;
        alu_src_e    <= alu_src_d;
        result_src_e <= result_src_d;
        alu_ctrl_e   <= alu_ctrl_d;
        funct3_e     <= funct3D;
        rd_e         <= rd_d;
      end
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      rd_m         <= rd_e;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

  // C is carry-out of A-B, so unsigned less-than is its complement
  assign lt  = NE ^ VE;
  assign ltu = ~CE;

  always_comb begin
    case (funct3_e)
      3'b000:  taken = ZeroE;
      3'b001:  taken = ~ZeroE;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  assign pc_src = jump_e | (branch_e & taken);

`ifdef LOAD_USE_STALL_EN
  logic unused_stall_in;
  assign unused_stall_in = StallIn;
  assign lw_stall = (result_src_e == 2'b01) && (rd_e != '0) && ((rd_e == Rs1D) || (rd_e == Rs2D));
`else
  logic unused_rs;
  assign unused_rs = ^{Rs1D, Rs2D};
  assign lw_stall  = StallIn;
`endif

  // A redirect discards the stalled instruction anyway, so flush wins over stall
  assign PCSrcE      = pc_src;
  assign StallF      = lw_stall & ~pc_src;
  assign StallD      = lw_stall & ~pc_src;
  assign FlushD      = pc_src;
  assign FlushE      = lw_stall | pc_src;
  assign ALUControlE = alu_ctrl_e;
  assign ALUSrcE     = alu_src_e;
  assign RdE         = rd_e;
  assign MemWriteM   = mem_write_m;
  assign RegWriteM   = reg_write_m;
  assign RdM         = rd_m;
  assign RegWriteW   = reg_write_w;
  assign ResultSrcW  = result_src_w;
  assign RdW         = rd_w;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: decode table through the pipe with a per-stage scoreboard, then hazard/branch/reset sequences.
`timescale 1ns/1ps
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7_5D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       ZeroE, NE, CE, VE, StallIn;
  logic [2:0] ImmSrcD;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, PCSrcE, MemWriteM;
  logic [1:0] ResultSrcW;
  logic       RegWriteM, RegWriteW;
  logic [4:0] RdE, RdM, RdW;
  logic       StallF, StallD, FlushD, FlushE;

  always #5 clk = ~clk;

  pipeline_control_unit dut (
    .clk(clk), .rst(rst), .opD(opD), .funct3D(funct3D), .funct7_5D(funct7_5D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE), .NE(NE), .CE(CE), .VE(VE),
    .StallIn(StallIn), .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .PCSrcE(PCSrcE), .MemWriteM(MemWriteM), .ResultSrcW(ResultSrcW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .RdE(RdE), .RdM(RdM), .RdW(RdW), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE)
  );

  typedef struct {
    logic [3:0] alu;
    logic       asrc;
    logic       rw;
    logic [1:0] rsrc;
    logic       mw;
    logic       br;
    logic       jp;
    logic [2:0] f3;
    logic [4:0] rd;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] rs1, rs2, rd;
    logic       z, n, c, v, sin;
    logic [2:0] imm;
    exp_t       e;
  } drv_t;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q_e[$], q_m[$], q_w[$];
  exp_t cur_e;
  drv_t tbl[20];
  drv_t d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  function automatic exp_t bubble();
    exp_t b;
    b.alu = 4'h0; b.asrc = 1'b0; b.rw = 1'b0; b.rsrc = 2'b00; b.mw = 1'b0;
    b.br = 1'b0; b.jp = 1'b0; b.f3 = 3'b000; b.rd = 5'd0;
    return b;
  endfunction

  function automatic drv_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic [4:0] rd, input logic [2:0] imm, input logic [3:0] alu,
                              input logic asrc, input logic rw, input logic [1:0] rsrc,
                              input logic mw, input logic br, input logic jp);
    drv_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.rs1 = 5'd0; r.rs2 = 5'd0; r.rd = rd;
    r.z = 1'b0; r.n = 1'b0; r.c = 1'b0; r.v = 1'b0; r.sin = 1'b0; r.imm = imm;
    r.e.alu = alu; r.e.asrc = asrc; r.e.rw = rw; r.e.rsrc = rsrc; r.e.mw = mw;
    r.e.br = br; r.e.jp = jp; r.e.f3 = f3; r.e.rd = rd;
    return r;
  endfunction

  function automatic drv_t f_add(input logic [4:0] rd);
    return mk(7'b0110011, 3'b000, 1'b0, rd, 3'b000, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic drv_t f_lw(input logic [4:0] rd);
    return mk(7'b0000011, 3'b010, 1'b0, rd, 3'b000, 4'h0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic drv_t f_br(input logic [2:0] f3);
    return mk(7'b1100011, f3, 1'b0, 5'd0, 3'b010, 4'h1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic drv_t f_nop();
    return mk(7'b0000000, 3'b000, 1'b0, 5'd0, 3'b000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n,
                                    input logic c, input logic v);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input drv_t s);
    exp_t ex;
    logic pcs, lws;
    opD = s.op; funct3D = s.f3; funct7_5D = s.f7; Rs1D = s.rs1; Rs2D = s.rs2; RdD = s.rd;
    ZeroE = s.z; NE = s.n; CE = s.c; VE = s.v; StallIn = s.sin;
    pcs = cur_e.jp | (cur_e.br & br_taken(cur_e.f3, s.z, s.n, s.c, s.v));
`ifdef LOAD_USE_STALL_EN
    lws = (cur_e.rsrc == 2'b01) && (cur_e.rd != 5'd0) && ((cur_e.rd == s.rs1) || (cur_e.rd == s.rs2));
`else
    lws = s.sin;
`endif
    @(negedge clk);
    chk("ImmSrcD", 32'(ImmSrcD), 32'(s.imm));
    chk("PCSrcE", 32'(PCSrcE), 32'(pcs));
    chk("StallF", 32'(StallF), 32'(lws & ~pcs));
    chk("StallD", 32'(StallD), 32'(lws & ~pcs));
    chk("FlushD", 32'(FlushD), 32'(pcs));
    chk("FlushE", 32'(FlushE), 32'(lws | pcs));
    q_e.push_back((lws || pcs) ? bubble() : s.e);
    @(posedge clk);
    #1;
    if (q_w.size() > 0) begin
      ex = q_w.pop_front();
      chk("RegWriteW", 32'(RegWriteW), 32'(ex.rw));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(ex.rsrc));
      chk("RdW", 32'(RdW), 32'(ex.rd));
    end
    if (q_m.size() > 0) begin
      ex = q_m.pop_front();
      chk("MemWriteM", 32'(MemWriteM), 32'(ex.mw));
      chk("RegWriteM", 32'(RegWriteM), 32'(ex.rw));
      chk("RdM", 32'(RdM), 32'(ex.rd));
      q_w.push_back(ex);
    end
    if (q_e.size() > 0) begin
      ex = q_e.pop_front();
      chk("ALUControlE", 32'(ALUControlE), 32'(ex.alu));
      chk("ALUSrcE", 32'(ALUSrcE), 32'(ex.asrc));
      chk("RdE", 32'(RdE), 32'(ex.rd));
      q_m.push_back(ex);
      cur_e = ex;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    opD = 7'd0; funct3D = 3'd0; funct7_5D = 1'b0; Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
    ZeroE = 1'b0; NE = 1'b0; CE = 1'b0; VE = 1'b0; StallIn = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_ALUControlE", 32'(ALUControlE), 32'd0);
    chk("rst_ALUSrcE", 32'(ALUSrcE), 32'd0);
    chk("rst_RdE", 32'(RdE), 32'd0);
    chk("rst_MemWriteM", 32'(MemWriteM), 32'd0);
    chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("rst_RdM", 32'(RdM), 32'd0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_ResultSrcW", 32'(ResultSrcW), 32'd0);
    chk("rst_RdW", 32'(RdW), 32'd0);
    chk("rst_PCSrcE", 32'(PCSrcE), 32'd0);
    chk("rst_StallF", 32'(StallF), 32'd0);
    chk("rst_FlushE", 32'(FlushE), 32'd0);
    rst = 1'b0;
    q_e.delete(); q_m.delete(); q_w.delete();
    q_m.push_back(bubble());
    q_w.push_back(bubble());
    cur_e = bubble();
  endtask

  initial begin
    cur_e = bubble();
    // Flags in entry k are seen while entry k-1 is in E; chosen so every table branch falls through
    tbl[0]  = f_add(5'd3);
    tbl[1]  = mk(7'b0110011, 3'b000, 1'b1, 5'd4,  3'b000, 4'h1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(7'b0110011, 3'b101, 1'b1, 5'd7,  3'b000, 4'h9, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(7'b0110011, 3'b011, 1'b0, 5'd8,  3'b000, 4'h6, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(7'b0010011, 3'b000, 1'b1, 5'd9,  3'b000, 4'h0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(7'b0010011, 3'b101, 1'b0, 5'd10, 3'b000, 4'h8, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(7'b0010011, 3'b101, 1'b1, 5'd11, 3'b000, 4'h9, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(7'b0010011, 3'b111, 1'b0, 5'd12, 3'b000, 4'h2, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[8]  = f_lw(5'd13);
    tbl[9]  = mk(7'b0100011, 3'b010, 1'b0, 5'd5,  3'b001, 4'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    tbl[10] = f_br(3'b000);
    tbl[11] = f_br(3'b001);
    tbl[12] = f_br(3'b100);
    tbl[12].z = 1'b1;
    tbl[13] = f_br(3'b111);
    tbl[14] = mk(7'b0110111, 3'b000, 1'b0, 5'd14, 3'b100, 4'hA, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(7'b1111111, 3'b000, 1'b0, 5'd15, 3'b000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    tbl[15].e.rd = 5'd0;
    tbl[16] = mk(7'b1101111, 3'b000, 1'b0, 5'd1,  3'b011, 4'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    tbl[17] = f_add(5'd2);
    tbl[18] = mk(7'b1100111, 3'b000, 1'b0, 5'd5,  3'b000, 4'h0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    tbl[19] = f_add(5'd6);

    do_reset(2);
    for (int i = 0; i < 20; i++) step(tbl[i]);
    repeat (3) step(f_nop());

    // beq taken flushes the following add; beq not taken lets it through
    step(f_br(3'b000));
    d = f_add(5'd6); d.z = 1'b1; step(d);
    step(f_br(3'b000));
    d = f_add(5'd6); d.z = 1'b0; step(d);

    // signed / unsigned compares
    step(f_br(3'b100));
    d = f_nop(); d.n = 1'b1; d.v = 1'b0; step(d);
    step(f_br(3'b100));
    d = f_nop(); d.n = 1'b1; d.v = 1'b1; step(d);
    step(f_br(3'b110));
    d = f_nop(); d.c = 1'b0; step(d);
    step(f_br(3'b111));
    d = f_nop(); d.c = 1'b1; step(d);
    step(f_br(3'b101));
    d = f_nop(); d.n = 1'b1; d.v = 1'b0; step(d);

    // load-use: the held add is re-presented in D after the stall bubble
    step(f_lw(5'd5));
    d = f_add(5'd6); d.rs1 = 5'd5; d.rs2 = 5'd1; d.sin = 1'b1; step(d);
    d.sin = 1'b0; step(d);
    step(f_lw(5'd7));
    d = f_add(5'd8); d.rs1 = 5'd1; d.rs2 = 5'd7; d.sin = 1'b1; step(d);
    d.sin = 1'b0; step(d);
    step(f_lw(5'd5));
    d = f_add(5'd6); d.rs1 = 5'd4; d.rs2 = 5'd6; step(d);
    step(f_lw(5'd0));
    d = f_add(5'd6); d.rs1 = 5'd0; d.rs2 = 5'd0; step(d);
    repeat (3) step(f_nop());

    // taken branch coinciding with a load-use request: redirect wins
    step(f_br(3'b000));
    d = f_add(5'd6); d.rs1 = 5'd5; d.sin = 1'b1; d.z = 1'b1; step(d);
    repeat (3) step(f_nop());

    // reset with instructions in flight, then one add traced to W
    step(f_lw(5'd9));
    step(f_jal_like());
    do_reset(1);
    step(f_add(5'd3));
    repeat (3) step(f_nop());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic drv_t f_jal_like();
    return mk(7'b1101111, 3'b000, 1'b0, 5'd1, 3'b011, 4'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
  endfunction

endmodule
